// File: rtl/encoder_input_loader.sv
// ---------------------------------------------------------------------------
// encoder_input_loader
//
// Converts a valid/ready stream of signed fixed-point words into the flat,
// parallel frame vector consumed by encoder_fixed_point. Two frame banks let
// one frame fill while the other is held stable on x for the encoder.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    sample word (BITSIZE bits, passed through bit-exact)
//   in_valid   in_data / in_last are valid
//   in_last    final word of a frame
//   in_ready   loader accepts a word this cycle
//   x          assembled frame, word k at x[k*BITSIZE +: BITSIZE]
//   x_valid    x holds a complete frame
//   x_ready    consumer takes the frame
//   frame_err  one-cycle pulse after a short or long frame is detected
// ---------------------------------------------------------------------------
module encoder_input_loader #(
  parameter int N_input = 9,
  parameter int BITSIZE = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BITSIZE-1:0]         in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [N_input*BITSIZE-1:0] x,
  output logic                       x_valid,
  input  logic                       x_ready,
  output logic                       frame_err
);

  localparam int IDX_W = (N_input > 1) ? $clog2(N_input) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_input - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_DROP = 1'b1
  } state_t;

  state_t             r_state;
  logic [BITSIZE-1:0] r_bank [2][N_input];
  logic [1:0]         r_full;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [IDX_W-1:0]   r_idx;
  logic               r_frame_err;

  logic w_accept;
  logic w_write;
  logic w_commit;
  logic w_release;
  logic w_at_last;

  // In DROP the loader swallows words regardless of bank occupancy.
  assign in_ready  = (r_state == S_DROP) || !r_full[r_wr_bank];
  assign x_valid   = r_full[r_rd_bank];
  assign frame_err = r_frame_err;

  assign w_accept  = in_valid && in_ready;
  assign w_write   = w_accept && (r_state == S_FILL);
  assign w_at_last = (r_idx == LAST_IDX);
  assign w_commit  = w_write && in_last && w_at_last;
  assign w_release = x_valid && x_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_input; gi++) begin : g_x
      assign x[gi*BITSIZE +: BITSIZE] = r_bank[r_rd_bank][gi];
    end
  endgenerate

  // Frame storage: a written slot is only ever the wr_bank slot at idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_input; k++) begin
          r_bank[b][k] <= '0;
        end
      end
    end else if (w_write) begin
      r_bank[r_wr_bank][r_idx] <= in_data;
    end
  end

  // Control FSM. A commit only targets a bank that is not full and a release
  // only targets a full bank, so both can occur in one cycle on different
  // banks without conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_idx       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;

      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end

      if (w_commit) begin
        r_full[r_wr_bank] <= 1'b1;
      end

      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (in_last) begin
              // Either a complete frame (commit) or a short one (discard).
              r_idx <= '0;
              if (w_at_last) begin
                r_wr_bank <= ~r_wr_bank;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else if (w_at_last) begin
              // Long frame: drop the rest of it up to its in_last.
              r_idx       <= '0;
              r_state     <= S_DROP;
              r_frame_err <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DROP: begin
          if (w_accept && in_last) begin
            r_state <= S_FILL;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= S_FILL;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_input_loader.sv
module tb_encoder_input_loader;

  localparam int N = 9;
  localparam int B = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [B-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [N*B-1:0] x;
  logic           x_valid;
  logic           x_ready;
  logic           frame_err;

  always #5 clk = ~clk;

  encoder_input_loader #(.N_input(N), .BITSIZE(B)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .x(x), .x_valid(x_valid),
    .x_ready(x_ready), .frame_err(frame_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [N*B-1:0] act, input logic [N*B-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [N*B-1:0] lit(input logic [B-1:0] base);
    logic [N*B-1:0] v;
    for (int k = 0; k < N; k++) v[k*B +: B] = base + B'(k);
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // Held frames form a FIFO of depth two; the partially filled frame is a
  // queue of words; a drop flag swallows the tail of an over-long frame.
  logic [B-1:0]   m_cur[$];
  logic [N*B-1:0] m_held[$];
  bit             m_drop;
  bit             m_err;
  bit             m_acc;

  function automatic bit m_ready();
    return m_drop || (m_held.size() < 2);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [N*B-1:0] f;
    bit acc;
    if (rst) begin
      m_cur.delete();
      m_held.delete();
      m_drop = 1'b0;
      m_err  = 1'b0;
      m_acc  = 1'b0;
    end else begin
      acc   = in_valid && m_ready();
      m_err = 1'b0;
      if (m_held.size() > 0 && x_ready) void'(m_held.pop_front());
      if (acc) begin
        if (m_drop) begin
          if (in_last) m_drop = 1'b0;
        end else begin
          m_cur.push_back(in_data);
          if (in_last) begin
            if (m_cur.size() == N) begin
              for (int k = 0; k < N; k++) f[k*B +: B] = m_cur[k];
              m_held.push_back(f);
            end else begin
              m_err = 1'b1;
            end
            m_cur.delete();
          end else if (m_cur.size() == N) begin
            m_err  = 1'b1;
            m_drop = 1'b1;
            m_cur.delete();
          end
        end
      end
      m_acc = acc;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk_int("in_ready", int'(in_ready), int'(m_ready()));
      chk_int("x_valid", int'(x_valid), int'(m_held.size() > 0));
      chk_int("frame_err", int'(frame_err), int'(m_err));
      if (m_held.size() > 0) chk_vec("x", x, m_held[0]);
    end
  end

  // ---------------- observers ----------------
  int             cyc = 0;
  logic [N*B-1:0] out_q[$];
  int             out_t[$];
  int             err_cnt = 0;
  int             stall_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (x_valid && x_ready) begin
        out_q.push_back(x);
        out_t.push_back(cyc);
      end
      if (frame_err) err_cnt++;
      if (in_valid && !in_ready) stall_cnt++;
    end
  end

  // x_ready driver: 0 = hold off, 1 = always ready, 2 = random.
  int xr_mode = 1;
  always @(posedge clk) begin
    #2;
    if (xr_mode == 2) x_ready = 1'($urandom_range(0, 1));
    else              x_ready = (xr_mode == 1);
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [B-1:0] d, input logic last);
    int n;
    n = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (m_acc) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("[TB] FAIL accept_timeout: word %h not accepted within 200 cycles", d);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [B-1:0] base, input int len);
    for (int k = 0; k < len; k++) send_word(base + B'(k), k == len - 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_rand(input int len);
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_word($urandom, k == len - 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n0, e0, s0, len, r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; x_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_vec("rst_x", x, '0);
    chk_int("rst_x_valid", int'(x_valid), 0);
    chk_int("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_int("post_rst_in_ready", int'(in_ready), 1);

    // Single frame 1..9
    n0 = out_q.size(); e0 = err_cnt;
    send_frame(32'h1, 9);
    chk_int("single_x_valid", int'(x_valid), 1);
    chk_vec("single_x", x, lit(32'h1));
    @(posedge clk);
    #1;
    chk_int("single_pulse_end", int'(x_valid), 0);
    chk_int("single_count", out_q.size() - n0, 1);
    chk_int("single_no_err", err_cnt - e0, 0);

    // Back-pressure: three frames with x_ready held low
    xr_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    n0 = out_q.size();
    send_frame(32'd1, 9);
    send_frame(32'd10, 9);
    chk_int("bp_in_ready_low", int'(in_ready), 0);
    chk_vec("bp_first_held", x, lit(32'd1));
    fork
      send_frame(32'd19, 9);
      begin
        repeat (5) @(posedge clk);
        #1;
        xr_mode = 1;
      end
    join
    idle(20);
    chk_int("bp_count", out_q.size() - n0, 3);
    if (out_q.size() - n0 >= 3) begin
      chk_vec("bp_order0", out_q[n0],     lit(32'd1));
      chk_vec("bp_order1", out_q[n0 + 1], lit(32'd10));
      chk_vec("bp_order2", out_q[n0 + 2], lit(32'd19));
    end

    // Short frame then a good frame A0..A8
    n0 = out_q.size(); e0 = err_cnt;
    send_frame(32'h55, 5);
    idle(3);
    chk_int("short_err", err_cnt - e0, 1);
    chk_int("short_no_out", out_q.size() - n0, 0);
    send_frame(32'hA0, 9);
    idle(3);
    chk_int("short_next_count", out_q.size() - n0, 1);
    if (out_q.size() > n0) chk_vec("short_next_x", out_q[n0], lit(32'hA0));

    // Long frame of 12 words then a good frame
    n0 = out_q.size(); e0 = err_cnt;
    send_frame(32'h200, 12);
    idle(3);
    chk_int("long_err", err_cnt - e0, 1);
    chk_int("long_no_out", out_q.size() - n0, 0);
    send_frame(32'h300, 9);
    idle(3);
    chk_int("long_next_count", out_q.size() - n0, 1);
    if (out_q.size() > n0) chk_vec("long_next_x", out_q[n0], lit(32'h300));

    // Reset with one frame held and a partial frame in progress
    xr_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(32'h400, 9);
    for (int k = 0; k < 4; k++) send_word(32'h500 + B'(k), 1'b0);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk_int("midrst_x_valid", int'(x_valid), 0);
    chk_vec("midrst_x", x, '0);
    chk_int("midrst_frame_err", int'(frame_err), 0);
    xr_mode = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n0 = out_q.size();
    send_frame(32'h600, 9);
    idle(3);
    chk_int("midrst_count", out_q.size() - n0, 1);
    if (out_q.size() > n0) chk_vec("midrst_next_x", out_q[n0], lit(32'h600));

    // Full rate: four back-to-back frames
    n0 = out_q.size(); s0 = stall_cnt;
    for (int f = 0; f < 4; f++) send_frame(32'h700 + B'(f * 9), 9);
    idle(4);
    chk_int("fullrate_stalls", stall_cnt - s0, 0);
    chk_int("fullrate_count", out_q.size() - n0, 4);
    if (out_q.size() - n0 >= 4) begin
      for (int f = 0; f < 4; f++) begin
        chk_vec("fullrate_x", out_q[n0 + f], lit(32'h700 + B'(f * 9)));
        if (f > 0) chk_int("fullrate_spacing", out_t[n0 + f] - out_t[n0 + f - 1], 9);
      end
    end

    // Randomized traffic with random consumer back-pressure
    xr_mode = 2;
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      len = $urandom_range(1, 8);
      else if (r == 1) len = $urandom_range(10, 13);
      else             len = 9;
      send_rand(len);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    xr_mode = 1;
    idle(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
